bcd_disp_timer: RTL and testbench
=================================

BCD_DISP_TIMER -- requirements
Module: bcd_disp_timer

Interface
REQ-001 SHALL have parameter DIGITS, default 2, number of BCD digits/display positions (legal 1..8).
REQ-002 SHALL have parameter TICK_DIV, default 2_000_000, clk cycles per count tick (legal >=2).
REQ-003 SHALL have parameter SCAN_DIV, default 4, clk cycles each digit is driven during scan (legal >=1).
REQ-004 SHALL have parameter BLANK_LZ, default 1, 1 = blank leading zeros.
REQ-005 SHALL have parameter DP_POS, default 1, digit index showing decimal point; >=DIGITS = never.
REQ-006 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  input  1  level, sampled each clk; begin counting from zero.
REQ-009 SHALL have port stop  input  1  level, sampled each clk; freeze count.
REQ-010 SHALL have port clear  input  1  level, sampled each clk; return to IDLE, zero count.
REQ-011 SHALL have port value  output  4*DIGITS  BCD count, digit 0 in bits [3:0].
REQ-012 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-013 SHALL have port dp  output  1  decimal point, active-high.
REQ-014 SHALL have port digit_sel  output  DIGITS  one-hot active-high digit enable.
REQ-015 SHALL have port running  output  1  high in RUN.
REQ-016 SHALL have port overflow  output  1  sticky, count saturated.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-018 SHALL give clear priority over start/stop in every state: next state IDLE, value 0, overflow 0.
REQ-019 SHALL, in IDLE or DONE with start=1 (clear=0), enter RUN next cycle with value 0, overflow 0, tick counter 0.
REQ-020 SHALL, in RUN with stop=1, enter DONE next cycle, holding value; start ignored in RUN, stop ignored in IDLE/DONE.
REQ-021 SHALL run tick counter 0..TICK_DIV-1 only in RUN, wrapping to 0; tick = counter==TICK_DIV-1; counter held at 0 outside RUN.
REQ-022 SHALL increment value by 1 (decimal ripple carry, each digit 0..9) on the cycle after tick.
REQ-023 SHALL, on a tick with value all 9s, keep value all 9s, set overflow, enter DONE.
REQ-024 SHALL, if stop and tick coincide in RUN, apply the increment and enter DONE.
REQ-025 SHALL run scan counter 0..SCAN_DIV-1 continuously in all states; on wrap advance digit index 0..DIGITS-1, wrapping to 0.
REQ-026 SHALL register seg, dp, digit_sel; they reflect digit index and value of the previous cycle (1-cycle latency).
REQ-027 SHALL drive digit_sel[idx]=1, all other bits 0, in all states after reset.
REQ-028 SHALL encode digits 0..9 as 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.
REQ-029 SHALL drive seg=0 and dp=0 in IDLE.
REQ-030 SHALL, with BLANK_LZ=1, drive seg=0 for digit idx>0 when that digit and all higher digits are 0; digit 0 never blanked.
REQ-031 SHALL drive dp=1 when idx==DP_POS and state is RUN or DONE, regardless of blanking.

Reset
REQ-032 SHALL, while reset=1, force state IDLE, value 0, overflow 0, running 0, tick and scan counters 0, idx 0, seg 0, dp 0, digit_sel = 1 (bit 0 only).
REQ-033 SHALL, on reset mid-RUN, abandon count immediately; no tick or increment on the first cycle after deassertion.

Verification
REQ-034 SHALL cover DIGITS=2, TICK_DIV=4: start pulse -> running=1 next cycle, value 8'h01 after 4 clks, 8'h10 after 40 clks.
REQ-035 SHALL cover 2 digits at 8'h99, tick -> value stays 8'h99, overflow=1, running=0, state DONE; start -> value 8'h00, overflow=0.
REQ-036 SHALL cover stop at value 8'h07 -> value holds 8'h07 for 100 clks; clear -> value 0, seg 0, dp 0 next cycle.
REQ-037 SHALL cover SCAN_DIV=2, DIGITS=3 -> digit_sel 001,001,010,010,100,100,001 repeating, one cycle behind scan index.
REQ-038 SHALL cover BLANK_LZ=1, value 12'h005 in RUN -> digit2 seg 0, digit1 seg 0 with dp 1, digit0 seg 1101101.
REQ-039 SHALL cover reset asserted mid-RUN at value 8'h42 -> all outputs at reset values asynchronously; state IDLE after release.

Source files
------------

// File: rtl/bcd_disp_timer_if.sv
// Signal bundle for bcd_disp_timer: level-sampled controls in, BCD count and
// multiplexed 7-segment display drive out.
interface bcd_disp_timer_if #(
  parameter int DIGITS = 2
);
  // start/stop/clear are plain levels sampled on every rising clk; there is no
  // valid/ready handshake, so a control held for several cycles acts every cycle.
  // state_dbg encoding: 0 = IDLE, 1 = RUN, 2 = DONE.
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic [4*DIGITS-1:0]   value;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     digit_sel;
  logic                  running;
  logic                  overflow;
  logic [1:0]            state_dbg;

  modport master (
    output start, stop, clear,
    input  value, seg, dp, digit_sel, running, overflow, state_dbg
  );

  modport slave (
    input  start, stop, clear,
    output value, seg, dp, digit_sel, running, overflow, state_dbg
  );
endinterface

// File: rtl/bcd_disp_timer.sv
// Decimal up-counting timer with saturating overflow and a time-multiplexed
// 7-segment display driver (leading-zero blanking, fixed decimal point).
module bcd_disp_timer #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 2_000_000,
  parameter int SCAN_DIV = 4,
  parameter int BLANK_LZ = 1,
  parameter int DP_POS   = 1
) (
  input  logic               clk,
  input  logic               reset,
  bcd_disp_timer_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [IW-1:0] IDX_DP    = IW'(DP_POS);
  localparam logic          DP_USED   = (DP_POS < DIGITS);

  state_t              state_q, state_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic                overflow_q, overflow_d;
  logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   sel_q, sel_d;

  logic                tick;
  logic                all_nines;
  logic                carry;
  logic [4*DIGITS-1:0] value_inc;
  logic [4*DIGITS-1:0] upper;
  logic                blank;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b0111111;
      4'd1:    seg_enc = 7'b0000110;
      4'd2:    seg_enc = 7'b1011011;
      4'd3:    seg_enc = 7'b1001111;
      4'd4:    seg_enc = 7'b1100110;
      4'd5:    seg_enc = 7'b1101101;
      4'd6:    seg_enc = 7'b1111101;
      4'd7:    seg_enc = 7'b0000111;
      4'd8:    seg_enc = 7'b1111111;
      4'd9:    seg_enc = 7'b1101111;
      default: seg_enc = 7'b0000000;
    endcase
  endfunction

  // Decimal ripple increment; all_nines flags the saturation point.
  always_comb begin
    value_inc = value_q;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (value_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (value_q[4*i +: 4] == 4'd9) begin
          value_inc[4*i +: 4] = 4'd0;
        end else begin
          value_inc[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign tick = (state_q == S_RUN) && (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    overflow_d = overflow_q;
    tick_cnt_d = tick_cnt_q;
    if (bus.clear) begin
      state_d    = S_IDLE;
      value_d    = '0;
      overflow_d = 1'b0;
      tick_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_d    = S_RUN;
            value_d    = '0;
            overflow_d = 1'b0;
            tick_cnt_d = '0;
          end
        end
        S_RUN: begin
          tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
          if (tick) begin
            if (all_nines) begin
              overflow_d = 1'b1;
              state_d    = S_DONE;
            end else begin
              value_d = value_inc;
            end
          end
          if (bus.stop) state_d = S_DONE;
          // Counter parks at zero whenever we leave RUN.
          if (state_d != S_RUN) tick_cnt_d = '0;
        end
        default: begin
          state_d    = S_IDLE;
          value_d    = '0;
          overflow_d = 1'b0;
          tick_cnt_d = '0;
        end
      endcase
    end
  end

  // Scan runs free in every state so the display keeps refreshing.
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    upper = value_q >> {idx_q, 2'b00};
    blank = (BLANK_LZ != 0) && (idx_q != '0) && (upper == '0);
    sel_d = DIGITS'(1) << idx_q;
    dp_d  = (state_q != S_IDLE) && DP_USED && (idx_q == IDX_DP);
    seg_d = '0;
    if (state_q != S_IDLE && !blank) seg_d = seg_enc(upper[3:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      value_q    <= '0;
      overflow_q <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      sel_q      <= DIGITS'(1);
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      value_q    <= value_d;
      overflow_q <= overflow_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      sel_q      <= sel_d;
    end
  end

  assign bus.value     = value_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.digit_sel = sel_q;
  assign bus.running   = (state_q == S_RUN);
  assign bus.overflow  = overflow_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_bcd_disp_timer.sv
// Self-checking bench for bcd_disp_timer: directed scenarios plus random
// start/stop/clear traffic against an integer-level reference model.
module tb_bcd_disp_timer;

  localparam int D   = 3;
  localparam int TD  = 4;
  localparam int SD  = 2;
  localparam int BLZ = 1;
  localparam int DPP = 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk;
  logic reset;

  bcd_disp_timer_if #(.DIGITS(D)) bus ();

  bcd_disp_timer #(
    .DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(BLZ), .DP_POS(DPP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         total;
  int         bad;
  int         m_state;
  int         m_val;
  int         m_ov;
  int         m_ph;
  int         m_cyc;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [D-1:0] e_sel;
  logic [6:0] seg_tab [10];
  logic [2:0] scan_exp [8];

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    r = '0;
    for (int d = 0; d < D; d++) r[4*d +: 4] = 4'((v / pow10(d)) % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_val   = 0;
    m_ov    = 0;
    m_ph    = 0;
    m_cyc   = 0;
    e_seg   = '0;
    e_dp    = 1'b0;
    e_sel   = D'(1);
  endtask

  // One rising edge: display registers capture the pre-edge view, then the timer advances.
  task automatic model_update(input logic s, input logic p, input logic c);
    int idx;
    int upper;
    bit tick;
    idx   = (m_cyc / SD) % D;
    upper = m_val / pow10(idx);
    e_sel = D'(1) << idx;
    e_dp  = (m_state != M_IDLE) && (idx == DPP);
    if (m_state == M_IDLE || (BLZ != 0 && idx > 0 && upper == 0)) e_seg = '0;
    else e_seg = seg_tab[upper % 10];
    m_cyc++;
    if (c) begin
      m_state = M_IDLE; m_val = 0; m_ov = 0; m_ph = 0;
    end else if (m_state != M_RUN) begin
      if (s) begin
        m_state = M_RUN; m_val = 0; m_ov = 0; m_ph = 0;
      end
    end else begin
      tick = (m_ph == TD - 1);
      m_ph = (m_ph + 1) % TD;
      if (tick) begin
        if (m_val == pow10(D) - 1) begin
          m_ov = 1; m_state = M_DONE;
        end else begin
          m_val = m_val + 1;
        end
      end
      if (p) m_state = M_DONE;
      if (m_state != M_RUN) m_ph = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("value",     32'(bus.value),     32'(to_bcd(m_val)));
    check_eq("seg",       32'(bus.seg),       32'(e_seg));
    check_eq("dp",        32'(bus.dp),        32'(e_dp));
    check_eq("digit_sel", 32'(bus.digit_sel), 32'(e_sel));
    check_eq("running",   32'(bus.running),   32'(m_state == M_RUN));
    check_eq("overflow",  32'(bus.overflow),  32'(m_ov));
    check_eq("state",     32'(bus.state_dbg), 32'(m_state));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_value"}, 32'(bus.value),     32'h0);
    check_eq({tag, "_seg"},   32'(bus.seg),       32'h0);
    check_eq({tag, "_dp"},    32'(bus.dp),        32'h0);
    check_eq({tag, "_sel"},   32'(bus.digit_sel), 32'h1);
    check_eq({tag, "_run"},   32'(bus.running),   32'h0);
    check_eq({tag, "_ovf"},   32'(bus.overflow),  32'h0);
    check_eq({tag, "_state"}, 32'(bus.state_dbg), 32'h0);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic s, input logic p, input logic c);
    bus.start = s;
    bus.stop  = p;
    bus.clear = c;
    @(posedge clk);
    model_update(s, p, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until_val(input int target, input string tag);
    for (int n = 0; n < 6000 && m_val != target; n++) step(1'b0, 1'b0, 1'b0);
    check_eq(tag, 32'(bus.value), 32'(to_bcd(target)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad   = 0;
    seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    scan_exp = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clear = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Scan order from reset, one cycle behind the scan index.
    for (int t = 0; t < 8; t++) begin
      step(1'b0, 1'b0, 1'b0);
      check_eq("scan_seq", 32'(bus.digit_sel), 32'(scan_exp[t]));
    end

    // Start pulse, first tick after 4 clocks, 0x010 after 40.
    step(1'b1, 1'b0, 1'b0);
    check_eq("start_running", 32'(bus.running), 32'h1);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    check_eq("val_after4", 32'(bus.value), 32'h001);
    repeat (36) step(1'b0, 1'b0, 1'b0);
    check_eq("val_after40", 32'(bus.value), 32'h010);

    // Stop at 7 and hold, then clear.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    run_until_val(7, "reach7");
    step(1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 100; n++) begin
      step(1'b0, 1'b0, 1'b0);
      if (n % 25 == 0) check_eq("hold7", 32'(bus.value), 32'h007);
    end
    check_eq("hold7_end", 32'(bus.value), 32'h007);
    step(1'b0, 1'b0, 1'b1);
    check_eq("clear_value", 32'(bus.value), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("clear_seg", 32'(bus.seg), 32'h0);
    check_eq("clear_dp",  32'(bus.dp),  32'h0);

    // Saturation at all nines, then restart.
    step(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 6000 && m_state != M_DONE; n++) step(1'b0, 1'b0, 1'b0);
    check_eq("sat_value", 32'(bus.value),     32'h999);
    check_eq("sat_ovf",   32'(bus.overflow),  32'h1);
    check_eq("sat_run",   32'(bus.running),   32'h0);
    check_eq("sat_state", 32'(bus.state_dbg), 32'h2);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_eq("restart_value", 32'(bus.value),    32'h0);
    check_eq("restart_ovf",   32'(bus.overflow), 32'h0);

    // Leading-zero blanking and decimal point at 005.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    run_until_val(5, "reach5");
    step(1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 2 * SD * D + 2; n++) begin
      step(1'b0, 1'b0, 1'b0);
      if (e_sel == 3'b100) check_eq("blank_d2", 32'(bus.seg), 32'h0);
      if (e_sel == 3'b010) begin
        check_eq("blank_d1",  32'(bus.seg), 32'h0);
        check_eq("dp_d1",     32'(bus.dp),  32'h1);
      end
      if (e_sel == 3'b001) check_eq("seg_d0_5", 32'(bus.seg), 32'b1101101);
    end

    // Random control traffic.
    for (int n = 0; n < 3000; n++) begin
      step(logic'($urandom_range(0, 7) == 0),
           logic'($urandom_range(0, 15) == 0),
           logic'($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset in the middle of a run at 042.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    run_until_val(42, "reach42");
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (6) step(1'b0, 1'b0, 1'b0);
    check_eq("post_rst_state", 32'(bus.state_dbg), 32'h0);
    check_eq("post_rst_value", 32'(bus.value),     32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
